// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch predictor: data width, 2-bit
// direction counter encodings and the saturating counter step function.
package bp_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr == ST) begin
        nxt = ST;
      end else begin
        nxt = ctr + 2'd1;
      end
    end else begin
      if (ctr == SNT) begin
        nxt = SNT;
      end else begin
        nxt = ctr - 2'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, resolved-branch update and statistics signals of the branch
// predictor; slave is the predictor view, master the pipeline view.
interface branch_predictor_if
  import bp_pkg::*;
#(
  parameter int IDX_W = 6
) ();

  logic             fetch_valid_i;
  logic [XLEN-1:0]  fetch_pc_i;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             upd_valid_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_taken_i;
  logic [XLEN-1:0]  upd_target_i;
  logic             upd_mispred_i;
  logic [XLEN-1:0]  stat_br_o;
  logic [XLEN-1:0]  stat_miss_o;

  modport slave (
    input  fetch_valid_i, fetch_pc_i,
    input  upd_valid_i, upd_pc_i, upd_idx_i, upd_taken_i, upd_target_i, upd_mispred_i,
    output pred_taken_o, pred_target_o, pred_idx_o,
    output stat_br_o, stat_miss_o
  );

  modport master (
    output fetch_valid_i, fetch_pc_i,
    output upd_valid_i, upd_pc_i, upd_idx_i, upd_taken_i, upd_target_i, upd_mispred_i,
    input  pred_taken_o, pred_target_o, pred_idx_o,
    input  stat_br_o, stat_miss_o
  );

endinterface

// File: rtl/branch_predictor_sat_counter_table.sv
// Table of 2-bit saturating direction counters with one asynchronous read
// port and one read-modify-write update port.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] wr_ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign wr_ctr_d = ctr_next(ctr_q[wr_idx_i], wr_taken_i);

  // Counters start weakly not-taken; a reset edge drops any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with a direct-mapped BTB and branch
// statistics. Define BP_GSHARE_EN to hash the BHT index with global history.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int BTB_DEPTH = 16,
  parameter int GHR_W     = 6
) (
  input  logic clk,
  input  logic reset_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_W  = $clog2(BHT_DEPTH);
  localparam int BTB_IW = $clog2(BTB_DEPTH);
  localparam int TAG_W  = XLEN - BTB_IW - 2;

  logic              btb_valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]   btb_target_q [BTB_DEPTH];

  logic [IDX_W-1:0]  pc_idx_s;
  logic [IDX_W-1:0]  fetch_idx_s;
  logic [BTB_IW-1:0] fetch_bidx_s;
  logic [BTB_IW-1:0] upd_bidx_s;
  logic [TAG_W-1:0]  fetch_tag_s;
  logic [TAG_W-1:0]  upd_tag_s;
  logic [1:0]        fetch_ctr_s;
  logic              btb_hit_s;
  logic              pred_taken_s;
  logic [XLEN-1:0]   stat_br_q, stat_br_d;
  logic [XLEN-1:0]   stat_miss_q, stat_miss_d;
  logic              unused_s;

  assign pc_idx_s     = bp.fetch_pc_i[IDX_W+1:2];
  assign fetch_bidx_s = bp.fetch_pc_i[BTB_IW+1:2];
  assign fetch_tag_s  = bp.fetch_pc_i[XLEN-1:BTB_IW+2];
  assign upd_bidx_s   = bp.upd_pc_i[BTB_IW+1:2];
  assign upd_tag_s    = bp.upd_pc_i[XLEN-1:BTB_IW+2];
  assign unused_s     = ^bp.upd_pc_i[1:0];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign fetch_idx_s = pc_idx_s ^ IDX_W'(ghr_q);

  // History only advances on resolved branches, never on predictions.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.upd_valid_i) begin
      ghr_d = {ghr_q[GHR_W-2:0], bp.upd_taken_i};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  localparam int unused_ghr_w = GHR_W;

  assign fetch_idx_s = pc_idx_s;
`endif

  sat_counter_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_idx_i   (fetch_idx_s),
    .rd_ctr_o   (fetch_ctr_s),
    .wr_en_i    (bp.upd_valid_i),
    .wr_idx_i   (bp.upd_idx_i),
    .wr_taken_i (bp.upd_taken_i)
  );

  // Zero-latency lookup reads pre-update table state.
  always_comb begin
    btb_hit_s    = btb_valid_q[fetch_bidx_s] && (btb_tag_q[fetch_bidx_s] == fetch_tag_s);
    pred_taken_s = bp.fetch_valid_i & btb_hit_s & fetch_ctr_s[1];
    if (pred_taken_s) begin
      bp.pred_target_o = btb_target_q[fetch_bidx_s];
    end else begin
      bp.pred_target_o = bp.fetch_pc_i + 32'd4;
    end
  end

  assign bp.pred_taken_o = pred_taken_s;
  assign bp.pred_idx_o   = fetch_idx_s;

  // BTB entries are allocated only by taken branches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else if (bp.upd_valid_i && bp.upd_taken_i) begin
      btb_valid_q[upd_bidx_s]  <= 1'b1;
      btb_tag_q[upd_bidx_s]    <= upd_tag_s;
      btb_target_q[upd_bidx_s] <= bp.upd_target_i;
    end
  end

  // Saturating statistics counters; mispredict is qualified by upd_valid_i.
  always_comb begin
    stat_br_d   = stat_br_q;
    stat_miss_d = stat_miss_q;
    if (bp.upd_valid_i && (stat_br_q != {XLEN{1'b1}})) begin
      stat_br_d = stat_br_q + 32'd1;
    end else begin
      stat_br_d = stat_br_q;
    end
    if (bp.upd_valid_i && bp.upd_mispred_i && (stat_miss_q != {XLEN{1'b1}})) begin
      stat_miss_d = stat_miss_q + 32'd1;
    end else begin
      stat_miss_d = stat_miss_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_br_q   <= stat_br_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign bp.stat_br_o   = stat_br_q;
  assign bp.stat_miss_o = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; the BP_GSHARE_EN build
// runs the reset and history-hash scenarios.
module tb_branch_predictor;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  branch_predictor_if bus ();

  branch_predictor dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bp      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_upd();
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = 32'h0;
    bus.upd_idx_i     = 6'd0;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = 32'h0;
    bus.upd_mispred_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_upd();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic tk,
                     input logic [31:0] tgt, input logic mis);
    @(negedge clk);
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = pc;
    bus.upd_idx_i     = idx;
    bus.upd_taken_i   = tk;
    bus.upd_target_i  = tgt;
    bus.upd_mispred_i = mis;
    @(negedge clk);
    clear_upd();
  endtask

  task automatic lookup(input logic [31:0] pc);
    @(negedge clk);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = pc;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.stat_br_o !== 32'h0) $display("FAIL rst_stat_br: got %h want 0", bus.stat_br_o); else n_pass++;
    n_checks++;
    if (bus.stat_miss_o !== 32'h0) $display("FAIL rst_stat_miss: got %h want 0", bus.stat_miss_o); else n_pass++;
    reset_n = 1'b1;
    lookup(32'h100);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL rst_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h104) $display("FAIL rst_target: got %h want 104", bus.pred_target_o); else n_pass++;
    n_checks++;
    if (bus.pred_idx_o !== 6'd0) $display("FAIL rst_idx: got %0d want 0", bus.pred_idx_o); else n_pass++;
    lookup(32'hFFFF_FFFC);
    n_checks++;
    if (bus.pred_target_o !== 32'h0) $display("FAIL wrap_target: got %h want 0", bus.pred_target_o); else n_pass++;
    n_checks++;
    if (bus.pred_idx_o !== 6'd63) $display("FAIL wrap_idx: got %0d want 63", bus.pred_idx_o); else n_pass++;
  endtask

  task automatic test_train();
    do_reset();
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1);
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1);
    lookup(32'h100);
    n_checks++;
    if (bus.pred_taken_o !== 1'b1) $display("FAIL train_taken: got %b want 1", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h200) $display("FAIL train_target: got %h want 200", bus.pred_target_o); else n_pass++;
    @(negedge clk);
    bus.fetch_valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL novalid_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h104) $display("FAIL novalid_target: got %h want 104", bus.pred_target_o); else n_pass++;
  endtask

  task automatic test_hysteresis();
    do_reset();
    for (int i = 0; i < 5; i++) upd(32'h40, 6'd16, 1'b1, 32'h300, 1'b0);
    upd(32'h40, 6'd16, 1'b0, 32'h0, 1'b1);
    lookup(32'h40);
    n_checks++;
    if (bus.pred_taken_o !== 1'b1) $display("FAIL hyst1_taken: got %b want 1", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h300) $display("FAIL hyst1_target: got %h want 300", bus.pred_target_o); else n_pass++;
    upd(32'h40, 6'd16, 1'b0, 32'h0, 1'b1);
    lookup(32'h40);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL hyst2_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h44) $display("FAIL hyst2_target: got %h want 44", bus.pred_target_o); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(negedge clk);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = 32'h80;
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h80;
    bus.upd_idx_i     = 6'd32;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'h500;
    bus.upd_mispred_i = 1'b1;
    #1;
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL same_pre_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h84) $display("FAIL same_pre_target: got %h want 84", bus.pred_target_o); else n_pass++;
    @(negedge clk);
    clear_upd();
    #1;
    n_checks++;
    if (bus.pred_taken_o !== 1'b1) $display("FAIL same_post_taken: got %b want 1", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h500) $display("FAIL same_post_target: got %h want 500", bus.pred_target_o); else n_pass++;
    // 0x180 shares both the BHT slot and the BTB slot of 0x80 but not its tag.
    lookup(32'h180);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL alias_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'h184) $display("FAIL alias_target: got %h want 184", bus.pred_target_o); else n_pass++;
    upd(32'h80, 6'd32, 1'b0, 32'h0, 1'b0);
    lookup(32'h80);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL same_ctr10_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
  endtask

  task automatic test_btb_not_taken();
    do_reset();
    upd(32'h4C0, 6'd48, 1'b1, 32'h900, 1'b0);
    upd(32'h4C0, 6'd48, 1'b1, 32'h900, 1'b0);
    upd(32'hC0, 6'd5, 1'b0, 32'h700, 1'b0);
    lookup(32'hC0);
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL nt_btb_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    n_checks++;
    if (bus.pred_target_o !== 32'hC4) $display("FAIL nt_btb_target: got %h want c4", bus.pred_target_o); else n_pass++;
    lookup(32'h4C0);
    n_checks++;
    if (bus.pred_target_o !== 32'h900) $display("FAIL keep_btb_target: got %h want 900", bus.pred_target_o); else n_pass++;
  endtask

  task automatic test_stats();
    do_reset();
    upd(32'h10, 6'd4, 1'b1, 32'h20, 1'b1);
    upd(32'h10, 6'd4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    bus.upd_mispred_i = 1'b1;
    @(negedge clk);
    bus.upd_mispred_i = 1'b0;
    upd(32'h10, 6'd4, 1'b1, 32'h20, 1'b1);
    #1;
    n_checks++;
    if (bus.stat_br_o !== 32'd3) $display("FAIL stat_br: got %0d want 3", bus.stat_br_o); else n_pass++;
    n_checks++;
    if (bus.stat_miss_o !== 32'd2) $display("FAIL stat_miss: got %0d want 2", bus.stat_miss_o); else n_pass++;
    @(negedge clk);
    force dut.stat_miss_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_miss_q;
    #1;
    n_checks++;
    if (bus.stat_miss_o !== 32'hFFFF_FFFE) $display("FAIL miss_preload: got %h want fffffffe", bus.stat_miss_o); else n_pass++;
    upd(32'h10, 6'd4, 1'b0, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (bus.stat_miss_o !== 32'hFFFF_FFFF) $display("FAIL miss_max: got %h want ffffffff", bus.stat_miss_o); else n_pass++;
    upd(32'h10, 6'd4, 1'b0, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (bus.stat_miss_o !== 32'hFFFF_FFFF) $display("FAIL miss_sat: got %h want ffffffff", bus.stat_miss_o); else n_pass++;
    n_checks++;
    if (bus.stat_br_o !== 32'd5) $display("FAIL stat_br_after_sat: got %0d want 5", bus.stat_br_o); else n_pass++;
  endtask

  task automatic test_reset_mid_update();
    do_reset();
    @(negedge clk);
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h40;
    bus.upd_idx_i     = 6'd16;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'h300;
    bus.upd_mispred_i = 1'b1;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    clear_upd();
    @(negedge clk);
    reset_n = 1'b1;
    lookup(32'h40);
    n_checks++;
    if (bus.pred_target_o !== 32'h44) $display("FAIL midrst_target: got %h want 44", bus.pred_target_o); else n_pass++;
    n_checks++;
    if (bus.stat_br_o !== 32'd0) $display("FAIL midrst_stat_br: got %0d want 0", bus.stat_br_o); else n_pass++;
    n_checks++;
    if (bus.stat_miss_o !== 32'd0) $display("FAIL midrst_stat_miss: got %0d want 0", bus.stat_miss_o); else n_pass++;
  endtask

  task automatic test_gshare();
    do_reset();
    upd(32'h0, 6'd0, 1'b1, 32'h40, 1'b0);
    upd(32'h0, 6'd0, 1'b1, 32'h40, 1'b0);
    upd(32'h0, 6'd0, 1'b0, 32'h0, 1'b1);
    lookup(32'h0);
    n_checks++;
    if (bus.pred_idx_o !== 6'd6) $display("FAIL gshare_idx0: got %0d want 6", bus.pred_idx_o); else n_pass++;
    n_checks++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL gshare_taken: got %b want 0", bus.pred_taken_o); else n_pass++;
    lookup(32'h8);
    n_checks++;
    if (bus.pred_idx_o !== 6'd4) $display("FAIL gshare_idx8: got %0d want 4", bus.pred_idx_o); else n_pass++;
  endtask

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    reset_n           = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_pc_i    = 32'h0;
    clear_upd();
    test_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`else
    test_train();
    test_hysteresis();
    test_same_cycle();
    test_btb_not_taken();
    test_stats();
    test_reset_mid_update();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_DEPTH, 64, number of 2-bit direction counters; power of two, at least 4.
REQ-002 Parameter BTB_DEPTH, 16, number of target-buffer entries; power of two, at least 2.
REQ-003 Parameter GHR_W, 6, global history length; at most log2(BHT_DEPTH).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 fetch_valid_i  in  1  fetch PC is valid this cycle.
REQ-007 fetch_pc_i  in  32  PC being fetched.
REQ-008 pred_taken_o  out  1  predict taken for fetch_pc_i.
REQ-009 pred_target_o  out  32  next fetch PC.
REQ-010 pred_idx_o  out  log2(BHT_DEPTH)  BHT index used; carried down the pipeline for update.
REQ-011 upd_valid_i  in  1  a resolved branch is reported this cycle.
REQ-012 upd_pc_i  in  32  PC of the resolved branch.
REQ-013 upd_idx_i  in  log2(BHT_DEPTH)  pred_idx_o value captured at that branch's fetch.
REQ-014 upd_taken_i  in  1  actual branch outcome.
REQ-015 upd_target_i  in  32  actual taken target.
REQ-016 upd_mispred_i  in  1  branch was mispredicted.
REQ-017 stat_br_o  out  32  count of resolved branches.
REQ-018 stat_miss_o  out  32  count of mispredictions.

Function
REQ-019 Lookup is combinational, zero latency; outputs are a function of fetch_pc_i and current table state only.
REQ-020 BTB index = fetch_pc_i[log2(BTB_DEPTH)+1:2]; tag = the remaining upper PC bits; hit = valid and tag equal.
REQ-021 pred_taken_o SHALL be fetch_valid_i AND BTB hit AND BHT[pred_idx_o] bit 1.
REQ-022 pred_target_o SHALL be the BTB target when pred_taken_o is 1, else fetch_pc_i+4 (32-bit wrap; 0xFFFFFFFC -> 0x00000000).
REQ-023 Counters saturate: on upd_valid_i, BHT[upd_idx_i] increments if upd_taken_i, else decrements; 11 stays 11, 00 stays 00.
REQ-024 On upd_valid_i with upd_taken_i=1, BTB[upd_pc_i index] is written: valid=1, tag, target=upd_target_i; not-taken updates leave the BTB unchanged.
REQ-025 Lookup and update to the same entry in one cycle: lookup returns the pre-update value; new value is visible the next cycle.
REQ-026 History is non-speculative: on upd_valid_i, GHR <= {GHR[GHR_W-2:0], upd_taken_i}.
REQ-027 stat_br_o increments on upd_valid_i; stat_miss_o increments on upd_valid_i AND upd_mispred_i; both saturate at 0xFFFFFFFF.
REQ-028 upd_mispred_i with upd_valid_i=0 SHALL be ignored.

Reset
REQ-029 While reset_n=0: every BHT counter = 01 (weakly not-taken), every BTB valid = 0, GHR = 0, stat_br_o = stat_miss_o = 0.
REQ-030 Consequently, after reset pred_taken_o = 0 and pred_target_o = fetch_pc_i+4 for all PCs.
REQ-031 Reset asserted mid-update SHALL discard that update; no partially written entry survives.

Configuration
REQ-032 Macro BP_GSHARE_EN defined: pred_idx_o = fetch_pc_i[log2(BHT_DEPTH)+1:2] XOR zero-extended GHR.
REQ-033 Macro BP_GSHARE_EN undefined: pred_idx_o = fetch_pc_i[log2(BHT_DEPTH)+1:2]; no GHR register is instantiated; update behaviour otherwise unchanged.

Structure
REQ-034 Shared package bp_pkg holds: XLEN=32, counter encodings SNT=00/WNT=01/WT=10/ST=11, the saturating next-counter function.
REQ-035 One sub-module, sat_counter_table (BHT_DEPTH x 2-bit counters, one async read port, one write port), holds the BHT.

Verification
REQ-036 Reset, then fetch 0x100 -> pred_taken_o=0, pred_target_o=0x104.
REQ-037 Two taken updates at PC 0x100, target 0x200, idx from lookup -> next fetch 0x100 gives pred_taken_o=1, pred_target_o=0x200.
REQ-038 Five updates at PC 0x40 with taken=1, then one with taken=0 -> counter 10, still predicted taken; a second not-taken -> predicted not-taken.
REQ-039 Same-cycle lookup and taken update of PC 0x80 from reset -> lookup shows not-taken; next cycle BTB hit, counter 10.
REQ-040 BP_GSHARE_EN defined, GHR_W=6, updates taken,taken,not-taken -> GHR=000110; fetch 0x0 gives pred_idx_o=6.
REQ-041 stat_miss_o preloaded to 0xFFFFFFFF through repeated mispredicted updates -> further mispredict leaves 0xFFFFFFFF; stat_br_o keeps counting.
